// File: rtl/apb_ic_pkg.sv
// Shared defaults and sizing helpers for the APB data crossbar.
package apb_ic_pkg;

    localparam int NUM_SINKS_D   = 8;
    localparam int NUM_SOURCES_D = 4;
    localparam int DATA_WIDTH_D  = 32;
    localparam int ADDR_WIDTH_D  = 2;

    // Round-robin pointer width; a single-port arbiter still needs one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_ic_rr_arbiter.sv
// Round-robin arbiter: picks the first request at or above the pointer,
// wrapping around, and moves the pointer just past the winner.
module apb_ic_rr_arbiter
    import apb_ic_pkg::*;
#(
    parameter int N = NUM_SINKS_D,
    localparam int PW = ptr_width(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant_onehot,
    output logic [PW-1:0] grant_idx,
    output logic          any_grant
);

    logic [PW-1:0] ptr_reg;
    logic [PW-1:0] ptr_next;

    always_comb begin
        int idx;
        grant_onehot = '0;
        grant_idx    = '0;
        any_grant    = 1'b0;
        idx          = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_reg) + k) % N;
            if (!any_grant && req[idx]) begin
                any_grant         = 1'b1;
                grant_idx         = PW'(idx);
                grant_onehot[idx] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (any_grant) begin
            ptr_next = (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/apb_interconnect.sv
// Registered N-master x M-slave data crossbar with an independent
// round-robin arbiter per slave and one cycle of latency.
module apb_interconnect
    import apb_ic_pkg::*;
#(
    parameter int NUM_SINKS   = NUM_SINKS_D,
    parameter int NUM_SOURCES = NUM_SOURCES_D,
    parameter int DATA_WIDTH  = DATA_WIDTH_D,
    parameter int ADDR_WIDTH  = ADDR_WIDTH_D
) (
    input  logic                   pclk,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  master_data [NUM_SINKS],
    input  logic [ADDR_WIDTH-1:0]  dest_addrs  [NUM_SINKS],
    input  logic [NUM_SINKS-1:0]   valids,
    output logic [DATA_WIDTH-1:0]  slave_data  [NUM_SOURCES],
    output logic [NUM_SOURCES-1:0] slave_valids,
    output logic [NUM_SINKS-1:0]   grants
);

    localparam int PW = ptr_width(NUM_SINKS);

    logic [NUM_SINKS-1:0]   req_mat     [NUM_SOURCES];
    logic [NUM_SINKS-1:0]   onehot      [NUM_SOURCES];
    logic [PW-1:0]          win_idx     [NUM_SOURCES];
    logic [NUM_SOURCES-1:0] any_grant;
    logic [NUM_SINKS-1:0]   grants_next;

    logic [DATA_WIDTH-1:0]  slave_data_reg [NUM_SOURCES];
    logic [NUM_SOURCES-1:0] slave_valids_reg;
    logic [NUM_SINKS-1:0]   grants_reg;

    // Out-of-range destinations match no row, so they are silently dropped.
    always_comb begin
        for (int s = 0; s < NUM_SOURCES; s++) begin
            req_mat[s] = '0;
            for (int m = 0; m < NUM_SINKS; m++) begin
                req_mat[s][m] = valids[m]
                             && (dest_addrs[m] == ADDR_WIDTH'(s))
                             && (int'(dest_addrs[m]) < NUM_SOURCES);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : g_arb
            apb_ic_rr_arbiter #(
                .N (NUM_SINKS)
            ) u_arb (
                .clk          (pclk),
                .rst_n        (reset),
                .req          (req_mat[gi]),
                .grant_onehot (onehot[gi]),
                .grant_idx    (win_idx[gi]),
                .any_grant    (any_grant[gi])
            );
        end
    endgenerate

    // Each master targets one slave, so OR-ing the per-slave grants never collides.
    always_comb begin
        grants_next = '0;
        for (int s = 0; s < NUM_SOURCES; s++) begin
            grants_next = grants_next | onehot[s];
        end
    end

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < NUM_SOURCES; s++) begin
                slave_data_reg[s] <= '0;
            end
            slave_valids_reg <= '0;
            grants_reg       <= '0;
        end else begin
            for (int s = 0; s < NUM_SOURCES; s++) begin
                if (any_grant[s]) begin
                    slave_data_reg[s] <= master_data[win_idx[s]];
                end
            end
            slave_valids_reg <= any_grant;
            grants_reg       <= grants_next;
        end
    end

    assign slave_data   = slave_data_reg;
    assign slave_valids = slave_valids_reg;
    assign grants       = grants_reg;

endmodule

// File: tb/tb_apb_interconnect.sv
// Directed bench for apb_interconnect: reset, single requester, fairness,
// parallel slaves, hold, out-of-range drop and asynchronous mid-run reset.
module tb_apb_interconnect;

    logic        pclk;
    logic        reset;
    logic [31:0] master_data [8];
    logic [1:0]  dest_addrs  [8];
    logic [7:0]  valids;

    logic [31:0] slave_data  [4];
    logic [3:0]  slave_valids;
    logic [7:0]  grants;

    logic [31:0] slave_data3 [3];
    logic [2:0]  slave_valids3;
    logic [7:0]  grants3;

    int tests_run;
    int tests_failed;

    apb_interconnect dut (
        .pclk         (pclk),
        .reset        (reset),
        .master_data  (master_data),
        .dest_addrs   (dest_addrs),
        .valids       (valids),
        .slave_data   (slave_data),
        .slave_valids (slave_valids),
        .grants       (grants)
    );

    // Three-slave variant: destination 3 is out of range here.
    apb_interconnect #(
        .NUM_SINKS   (8),
        .NUM_SOURCES (3),
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (2)
    ) dut3 (
        .pclk         (pclk),
        .reset        (reset),
        .master_data  (master_data),
        .dest_addrs   (dest_addrs),
        .valids       (valids),
        .slave_data   (slave_data3),
        .slave_valids (slave_valids3),
        .grants       (grants3)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic clear_inputs();
        valids = 8'h00;
        for (int m = 0; m < 8; m++) begin
            master_data[m] = 32'h0;
            dest_addrs[m]  = 2'd0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        for (int m = 0; m < 8; m++) begin
            master_data[m] = 32'd100 + 32'(m);
            dest_addrs[m]  = 2'd0;
        end
        valids = 8'hFF;
        reset  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            tests_run++;
            if (grants !== 8'h00 || slave_valids !== 4'h0) begin
                tests_failed++;
                $display("FAIL reset_ctrl cycle %0d: grants=%h valids=%h, required 00 0", c, grants, slave_valids);
            end
            tests_run++;
            if (slave_data[0] !== 32'h0 || slave_data[1] !== 32'h0 ||
                slave_data[2] !== 32'h0 || slave_data[3] !== 32'h0) begin
                tests_failed++;
                $display("FAIL reset_data cycle %0d: %h %h %h %h, required all 0", c,
                         slave_data[0], slave_data[1], slave_data[2], slave_data[3]);
            end
        end
        reset = 1'b1;
        tick();
        $display("[TB] reset release: grants=%h slave_valids=%h slave_data[0]=%h", grants, slave_valids, slave_data[0]);
        tests_run++;
        if (grants !== 8'h01 || slave_valids !== 4'b0001 || slave_data[0] !== 32'd100) begin
            tests_failed++;
            $display("FAIL reset_first_grant: grants=%h valids=%h data0=%h, required 01 1 %h",
                     grants, slave_valids, slave_data[0], 32'd100);
        end
    endtask

    task automatic test_single();
        clear_inputs();
        do_reset();
        valids         = 8'h01;
        dest_addrs[0]  = 2'd2;
        master_data[0] = 32'hDEADBEEF;
        tick();
        $display("[TB] single: grants=%h slave_valids=%h slave_data[2]=%h", grants, slave_valids, slave_data[2]);
        tests_run++;
        if (slave_data[2] !== 32'hDEADBEEF || slave_valids !== 4'b0100 || grants !== 8'h01) begin
            tests_failed++;
            $display("FAIL single: data2=%h valids=%h grants=%h, required deadbeef 4 01",
                     slave_data[2], slave_valids, grants);
        end
        tests_run++;
        if (slave_data[0] !== 32'h0 || slave_data[1] !== 32'h0 || slave_data[3] !== 32'h0) begin
            tests_failed++;
            $display("FAIL single_others: %h %h %h, required 0 0 0", slave_data[0], slave_data[1], slave_data[3]);
        end
        master_data[0] = 32'h12345678;
        tick();
        $display("[TB] single track: grants=%h slave_data[2]=%h", grants, slave_data[2]);
        tests_run++;
        if (slave_data[2] !== 32'h12345678 || grants !== 8'h01 || slave_valids !== 4'b0100) begin
            tests_failed++;
            $display("FAIL single_track: data2=%h grants=%h valids=%h, required 12345678 01 4",
                     slave_data[2], grants, slave_valids);
        end
    endtask

    task automatic test_round_robin();
        clear_inputs();
        do_reset();
        for (int m = 0; m < 8; m++) begin
            master_data[m] = 32'(m);
            dest_addrs[m]  = 2'd1;
        end
        valids = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            logic [7:0] exp_g;
            exp_g = 8'h01 << (i % 8);
            tick();
            $display("[TB] rr step %0d: grants=%h slave_data[1]=%0d", i, grants, slave_data[1]);
            tests_run++;
            if (slave_data[1] !== 32'(i % 8) || grants !== exp_g || slave_valids !== 4'b0010) begin
                tests_failed++;
                $display("FAIL rr step %0d: data1=%0d grants=%h valids=%h, required %0d %h 2",
                         i, slave_data[1], grants, slave_valids, i % 8, exp_g);
            end
        end
    endtask

    task automatic test_parallel_and_hold();
        clear_inputs();
        do_reset();
        for (int m = 0; m < 4; m++) begin
            dest_addrs[m]  = 2'(m);
            master_data[m] = 32'hA0 + 32'(m);
        end
        valids = 8'h0F;
        tick();
        $display("[TB] parallel: grants=%h slave_valids=%h", grants, slave_valids);
        tests_run++;
        if (slave_valids !== 4'hF || grants !== 8'h0F) begin
            tests_failed++;
            $display("FAIL parallel_ctrl: valids=%h grants=%h, required f 0f", slave_valids, grants);
        end
        for (int s = 0; s < 4; s++) begin
            tests_run++;
            if (slave_data[s] !== 32'hA0 + 32'(s)) begin
                tests_failed++;
                $display("FAIL parallel_data%0d: %h, required %h", s, slave_data[s], 32'hA0 + 32'(s));
            end
        end
        valids = 8'h00;
        master_data[0] = 32'hFFFF_FFFF;
        tick();
        $display("[TB] hold: grants=%h slave_valids=%h", grants, slave_valids);
        tests_run++;
        if (slave_valids !== 4'h0 || grants !== 8'h00) begin
            tests_failed++;
            $display("FAIL hold_ctrl: valids=%h grants=%h, required 0 00", slave_valids, grants);
        end
        tests_run++;
        if (slave_data[0] !== 32'hA0 || slave_data[1] !== 32'hA1 ||
            slave_data[2] !== 32'hA2 || slave_data[3] !== 32'hA3) begin
            tests_failed++;
            $display("FAIL hold_data: %h %h %h %h, required a0 a1 a2 a3",
                     slave_data[0], slave_data[1], slave_data[2], slave_data[3]);
        end
    endtask

    task automatic test_out_of_range();
        clear_inputs();
        do_reset();
        valids         = 8'h01;
        dest_addrs[0]  = 2'd3;
        master_data[0] = 32'h55;
        for (int c = 0; c < 3; c++) begin
            tick();
            $display("[TB] oor cycle %0d: dut3 grants=%h valids=%h", c, grants3, slave_valids3);
            tests_run++;
            if (grants3 !== 8'h00 || slave_valids3 !== 3'b000 ||
                slave_data3[0] !== 32'h0 || slave_data3[1] !== 32'h0 || slave_data3[2] !== 32'h0) begin
                tests_failed++;
                $display("FAIL oor cycle %0d: grants=%h valids=%h data=%h %h %h, required 00 0 0 0 0",
                         c, grants3, slave_valids3, slave_data3[0], slave_data3[1], slave_data3[2]);
            end
        end
        tests_run++;
        if (slave_data[3] !== 32'h55 || slave_valids !== 4'b1000) begin
            tests_failed++;
            $display("FAIL oor_inrange4: data3=%h valids=%h, required 55 8", slave_data[3], slave_valids);
        end
    endtask

    task automatic test_mid_reset();
        clear_inputs();
        do_reset();
        for (int m = 0; m < 8; m++) begin
            master_data[m] = 32'(m) + 32'h10;
            dest_addrs[m]  = 2'd1;
        end
        valids = 8'hFF;
        for (int i = 0; i < 5; i++) tick();
        tests_run++;
        if (grants !== 8'h10 || slave_data[1] !== 32'h14) begin
            tests_failed++;
            $display("FAIL midrst_pre: grants=%h data1=%h, required 10 14", grants, slave_data[1]);
        end
        #2;
        reset = 1'b0;
        #1;
        $display("[TB] mid reset async: grants=%h slave_valids=%h slave_data[1]=%h", grants, slave_valids, slave_data[1]);
        tests_run++;
        if (grants !== 8'h00 || slave_valids !== 4'h0 || slave_data[1] !== 32'h0) begin
            tests_failed++;
            $display("FAIL midrst_async: grants=%h valids=%h data1=%h, required 00 0 0",
                     grants, slave_valids, slave_data[1]);
        end
        tick();
        tests_run++;
        if (grants !== 8'h00 || slave_valids !== 4'h0) begin
            tests_failed++;
            $display("FAIL midrst_held: grants=%h valids=%h, required 00 0", grants, slave_valids);
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic [7:0] exp_g;
            exp_g = 8'h01 << i;
            tick();
            $display("[TB] mid reset restart %0d: grants=%h slave_data[1]=%h", i, grants, slave_data[1]);
            tests_run++;
            if (grants !== exp_g || slave_data[1] !== 32'(i) + 32'h10) begin
                tests_failed++;
                $display("FAIL midrst_order %0d: grants=%h data1=%h, required %h %h",
                         i, grants, slave_data[1], exp_g, 32'(i) + 32'h10);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        clear_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_parallel_and_hold();
        test_out_of_range();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/apb_interconnect.md
Name: apb_interconnect

Overview:
- Registered N-master × M-slave data crossbar on the APB clock domain.
- Each master (sink) presents a data word, a destination slave index and a valid.
- Each slave (source) output has its own round-robin arbiter. The arbiter selects one requesting master and drives that master's data to the slave one cycle later.
- Sits between peripheral-side producers and APB slave data ports. There is no backpressure: losing masters keep their valid asserted and retry.

Parameters:
- NUM_SINKS, 8, number of master ports.
- NUM_SOURCES, 4, number of slave ports.
- DATA_WIDTH, 32, data word width.
- ADDR_WIDTH, 2, destination index width; must satisfy 2**ADDR_WIDTH >= NUM_SOURCES.

Ports:
- pclk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- master_data  input  [DATA_WIDTH-1:0] x NUM_SINKS (unpacked array)  per-master data.
- dest_addrs  input  [ADDR_WIDTH-1:0] x NUM_SINKS (unpacked array)  per-master target slave index.
- valids  input  NUM_SINKS  per-master request valid.
- slave_data  output  [DATA_WIDTH-1:0] x NUM_SOURCES (unpacked array)  registered data delivered to each slave.
- slave_valids  output  NUM_SOURCES  high for one cycle when slave_data[s] was updated by a grant.
- grants  output  NUM_SINKS  registered; bit m high when master m won arbitration in the previous cycle.

Behaviour:
- Request matrix (combinational): req[s][m] = valids[m] && (dest_addrs[m] == s) && (dest_addrs[m] < NUM_SOURCES).
  - An out-of-range address is dropped silently and never granted.
- Per-slave round-robin arbiter:
  - Each slave has a pointer ptr[s] (index width clog2(NUM_SINKS)).
  - Winner is the first m with req[s][m], searching from ptr[s] upward with wrap-around modulo NUM_SINKS.
  - On a grant, ptr[s] <= winner+1, wrapping NUM_SINKS-1 -> 0.
  - With no request, ptr[s] holds.
- A master targets at most one slave per cycle, so per-slave grants are one-hot and disjoint across slaves.
- Registered outputs, 1-cycle latency. At rising edge k, for each slave s with a winner w:
  - slave_data[s] <= master_data[w]
  - slave_valids[s] <= 1
  - grants[w] <= 1
- Slaves with no request: slave_data[s] holds its previous value; slave_valids[s] <= 0.
- Masters not granted: grants bit <= 0.
- A master holding valid stays eligible every cycle and is re-granted whenever it wins again. There is no one-shot consumption.
- Sole requester: granted every cycle. slave_data tracks master_data with 1-cycle delay.
- Inputs changing between edges: only values sampled at the edge matter. A change of valids or dest_addrs retargets the request the same cycle.
- Reset (reset==0), asynchronous, any time including mid-arbitration:
  - slave_data all 0, slave_valids 0, grants 0, all ptr[s] = 0.
  - Outputs stay at reset values while reset is low.
  - First possible grant is at the first rising edge after deassertion.
- After reset with all masters contending for one slave, service order is 0,1,2,…,NUM_SINKS-1,0…

Decomposition:
- Package apb_ic_pkg holds:
  - default constants NUM_SINKS_D=8, NUM_SOURCES_D=4, DATA_WIDTH_D=32, ADDR_WIDTH_D=2;
  - helper function for the pointer width (clog2).
- One sub-module, apb_ic_rr_arbiter:
  - parameter N;
  - inputs clk, rst_n, req[N];
  - outputs grant_onehot[N], grant_idx, any_grant;
  - owns the pointer register.
- The top generates NUM_SOURCES instances plus the request-matrix decode, data mux and output registers.

Test Plan:
- Reset: valids=8'hFF held, reset=0 for 5 cycles -> slave_data all 0, slave_valids=0, grants=0 throughout; after release, first grant appears one edge later.
- Single requester: valids=8'h01, dest_addrs[0]=2, master_data[0]=32'hDEADBEEF -> after one edge slave_data[2]=32'hDEADBEEF, slave_valids=4'b0100, grants=8'h01; other slaves hold 0.
- Round-robin fairness: all 8 masters target slave 1, master_data[m]=m -> slave_data[1] sequence 0,1,…,7,0 on consecutive cycles, grants one-hot rotating.
- Parallel slaves: masters 0..3 target slaves 0..3 respectively with distinct data -> all four slaves updated on the same edge, slave_valids=4'hF, grants=8'h0F.
- Hold and out-of-range: valids drops to 0 -> slave_data unchanged, slave_valids=0. With NUM_SOURCES=3, a master with dest=3 -> never granted, no slave updated.
- Mid-run reset: assert reset during contention on slave 1 with ptr at 5 -> outputs clear immediately, no clock needed; after release the grant order restarts at master 0.
